// File: rtl/multicycle_control_if.sv
// Unified memory port handshake between the multicycle controller and memory.
// The controller drives the request side; memory answers with a ready strobe.
interface multicycle_control_if;
  logic mem_req_o;
  logic mem_we_o;
  logic i_or_d_o;
  logic mem_ready_i;

  modport master (output mem_req_o, mem_we_o, i_or_d_o, input mem_ready_i);
  modport slave  (input mem_req_o, mem_we_o, i_or_d_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_control.sv
// Moore main-control FSM for a multicycle RV32I core with one shared ALU and one
// unified memory port. Also counts retired instructions.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode_i,
  input  logic                  zero_i,
  multicycle_control_if.master  mem,
  output logic                  ir_write_o,
  output logic                  pc_write_o,
  output logic                  pc_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [2:0]            alu_op_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic                  illegal_o,
  output logic [3:0]            state_o,
  output logic [COUNT_W-1:0]    instr_count_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    EXEC_LUI = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11
  } state_e;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [2:0] ALU_R   = 3'b000;
  localparam logic [2:0] ALU_I   = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_CMP = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = FETCH;
    mem.mem_req_o = 1'b0;
    mem.mem_we_o  = 1'b0;
    mem.i_or_d_o  = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    pc_src_o      = 1'b0;
    alu_src_a_o   = SRC_A_PC;
    alu_src_b_o   = SRC_B_REG;
    alu_op_o      = ALU_R;
    reg_write_o   = 1'b0;
    result_src_o  = RES_ALUOUT;
    illegal_o     = 1'b0;
    retire        = 1'b0;

    case (state_q)
      FETCH: begin
        mem.mem_req_o = 1'b1;
        alu_src_a_o   = SRC_A_PC;
        alu_src_b_o   = SRC_B_FOUR;
        alu_op_o      = ALU_ADD;
        ir_write_o    = mem.mem_ready_i;
        pc_write_o    = mem.mem_ready_i;
        state_d       = mem.mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute OldPC+imm into ALUOut for branch and JAL targets.
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
        case (opcode_i)
          OPC_R:          state_d = EXEC_R;
          OPC_I:          state_d = EXEC_I;
          OPC_LUI:        state_d = EXEC_LUI;
          OPC_LW, OPC_SW: state_d = MEM_ADDR;
          OPC_BEQ:        state_d = BRANCH;
          OPC_JAL:        state_d = JAL;
          default: begin
            illegal_o = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
        if (opcode_i == OPC_LW)      state_d = MEM_RD;
        else if (opcode_i == OPC_SW) state_d = MEM_WR;
        else                         state_d = FETCH;
      end
      MEM_RD: begin
        mem.mem_req_o = 1'b1;
        mem.i_or_d_o  = 1'b1;
        state_d       = mem.mem_ready_i ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MDR;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        mem.mem_req_o = 1'b1;
        mem.i_or_d_o  = 1'b1;
        mem.mem_we_o  = 1'b1;
        retire        = mem.mem_ready_i;
        state_d       = mem.mem_ready_i ? FETCH : MEM_WR;
      end
      EXEC_R: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_REG;
        alu_op_o    = ALU_R;
        state_d     = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_I;
        state_d     = ALU_WB;
      end
      EXEC_LUI: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_LUI;
        state_d     = ALU_WB;
      end
      ALU_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_ALUOUT;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_REG;
        alu_op_o    = ALU_CMP;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        // rd gets the already-advanced PC; PC takes the target held in ALUOut.
        reg_write_o  = 1'b1;
        result_src_o = RES_PC;
        pc_write_o   = 1'b1;
        pc_src_o     = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign count_d       = retire ? count_q + 1'b1 : count_q;
  assign state_o       = state_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: per-instruction state sequences built from the latency rules,
// per-state output table, and a counter model, compared every cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       req, we, iod, irw, pcw, pcs;
    logic [1:0] a, b;
    logic [2:0] op;
    logic       rw;
    logic [1:0] rs;
    logic       ill;
  } outs_t;

  logic        clk, reset, zero_i;
  logic [6:0]  opcode_i;
  logic        ir_write_o, pc_write_o, pc_src_o, reg_write_o, illegal_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, result_src_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  state_o;
  logic [31:0] instr_count_o;

  multicycle_control_if mem_if ();

  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i), .mem(mem_if.master),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .result_src_o(result_src_o), .illegal_o(illegal_o),
    .state_o(state_o), .instr_count_o(instr_count_o)
  );

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LUI = 7'b0110111, LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, JALO = 7'b1101111, BAD = 7'b0000000;

  int          errs = 0, checks = 0;
  bit          chk_en = 0;
  int          exp_st;
  outs_t       exp_o;
  logic [31:0] exp_cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic outs_t model(int st, logic [6:0] opc, logic z, logic rdy);
    outs_t o = '0;
    case (st)
      0:  begin o.req = 1; o.b = 2; o.op = 2; o.irw = rdy; o.pcw = rdy; end
      1:  begin o.a = 1; o.b = 1; o.op = 2;
                o.ill = !(opc inside {R, I, LUI, LW, SW, BEQ, JALO}); end
      2:  begin o.a = 2; o.b = 1; o.op = 2; end
      3:  begin o.req = 1; o.iod = 1; end
      4:  begin o.rw = 1; o.rs = 1; end
      5:  begin o.req = 1; o.iod = 1; o.we = 1; end
      6:  o.a = 2;
      7:  begin o.a = 2; o.b = 1; o.op = 1; end
      8:  begin o.a = 2; o.b = 1; o.op = 4; end
      9:  o.rw = 1;
      10: begin o.a = 2; o.op = 3; o.pcs = 1; o.pcw = z; end
      11: begin o.rw = 1; o.rs = 2; o.pcw = 1; o.pcs = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      32'(state_o),            32'(exp_st));
      chk("mem_req",    32'(mem_if.mem_req_o),   32'(exp_o.req));
      chk("mem_we",     32'(mem_if.mem_we_o),    32'(exp_o.we));
      chk("i_or_d",     32'(mem_if.i_or_d_o),    32'(exp_o.iod));
      chk("ir_write",   32'(ir_write_o),         32'(exp_o.irw));
      chk("pc_write",   32'(pc_write_o),         32'(exp_o.pcw));
      chk("pc_src",     32'(pc_src_o),           32'(exp_o.pcs));
      chk("alu_src_a",  32'(alu_src_a_o),        32'(exp_o.a));
      chk("alu_src_b",  32'(alu_src_b_o),        32'(exp_o.b));
      chk("alu_op",     32'(alu_op_o),           32'(exp_o.op));
      chk("reg_write",  32'(reg_write_o),        32'(exp_o.rw));
      chk("result_src", 32'(result_src_o),       32'(exp_o.rs));
      chk("illegal",    32'(illegal_o),          32'(exp_o.ill));
      chk("count",      instr_count_o,           exp_cnt);
    end
  end

  // One clock cycle in state st; zero_i is random except where it matters.
  task automatic step(int st, bit rdy, bit z);
    mem_if.mem_ready_i = rdy;
    zero_i = (st == 10) ? z : 1'($urandom_range(0, 1));
    exp_st = st;
    exp_o  = model(st, opcode_i, zero_i, rdy);
    chk_en = 1;
    @(posedge clk); #1;
  endtask

  // Whole instruction: fw fetch wait cycles, mw memory-state wait cycles.
  task automatic run_instr(logic [6:0] opc, bit z, int fw, int mw);
    int  sq[$];
    bit  rq[$];
    bit  ret = 1;
    opcode_i = opc;
    for (int k = 0; k < fw; k++) begin sq.push_back(0); rq.push_back(0); end
    sq.push_back(0); rq.push_back(1);
    sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    case (opc)
      R:    begin sq.push_back(6); sq.push_back(9); end
      I:    begin sq.push_back(7); sq.push_back(9); end
      LUI:  begin sq.push_back(8); sq.push_back(9); end
      BEQ:  sq.push_back(10);
      JALO: sq.push_back(11);
      LW: begin
        sq.push_back(2);
        for (int k = 0; k < mw; k++) sq.push_back(3);
        sq.push_back(3); sq.push_back(4);
      end
      SW: begin
        sq.push_back(2);
        for (int k = 0; k <= mw; k++) sq.push_back(5);
      end
      default: ret = 0;
    endcase
    while (rq.size() < sq.size()) rq.push_back(1'($urandom_range(0, 1)));
    // Memory states wait mw cycles, then complete.
    for (int k = fw + 2; k < sq.size(); k++) begin
      if (sq[k] == 3 || sq[k] == 5)
        rq[k] = (k == fw + 3 + mw) ? 1'b1 : 1'b0;
    end
    for (int k = 0; k < sq.size(); k++) step(sq[k], rq[k], z);
    if (ret) exp_cnt++;
  endtask

  initial begin
    reset = 0; opcode_i = BAD; zero_i = 0; mem_if.mem_ready_i = 0;
    #2;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_count", instr_count_o, 0);
    chk("rst_req",   32'(mem_if.mem_req_o), 1);
    @(posedge clk); #1;
    reset = 1;

    run_instr(R, 0, 0, 0);
    chk("cnt_after_R", instr_count_o, 1);
    run_instr(LW, 0, 0, 3);
    chk("cnt_after_LW", instr_count_o, 2);
    run_instr(BEQ, 1, 0, 0);
    run_instr(BEQ, 0, 0, 0);
    chk("cnt_after_BEQx2", instr_count_o, 4);
    run_instr(BAD, 0, 0, 0);
    chk("cnt_after_illegal", instr_count_o, 4);
    run_instr(R, 0, 5, 0);
    run_instr(I, 0, 0, 0);
    run_instr(LUI, 0, 0, 0);
    run_instr(SW, 0, 0, 2);
    run_instr(JALO, 0, 1, 0);
    chk("cnt_after_mix", instr_count_o, 9);
    run_instr(SW, 0, 0, 0);
    chk("cnt_after_SW0", instr_count_o, 10);

    // Store in flight, then asynchronous reset while waiting in MEM_WR.
    opcode_i = SW;
    step(0, 1, 0);
    step(1, 1, 0);
    step(2, 1, 0);
    mem_if.mem_ready_i = 0;
    exp_st = 5; exp_o = model(5, SW, zero_i, 0); chk_en = 1;
    @(negedge clk); #1;
    chk_en = 0;
    chk("pre_rst_we", 32'(mem_if.mem_we_o), 1);
    reset = 0;
    #1;
    chk("async_rst_we",    32'(mem_if.mem_we_o), 0);
    chk("async_rst_state", 32'(state_o), 0);
    chk("async_rst_count", instr_count_o, 0);
    @(posedge clk); #1;
    reset = 1;
    exp_cnt = 0;
    run_instr(R, 0, 0, 0);
    chk("cnt_after_rst_R", instr_count_o, 1);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for a multicycle RV32I core that shares one ALU and one unified memory port across fetch, address, execute and branch steps.
- Per state it drives ALU operand selects and the 3-bit ALU_Op consumed by the ALU control decoder, plus memory handshake, register-file and PC strobes.
- Keeps a retired-instruction counter.

Parameters:
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode_i  input  7  IR[6:0] of the held instruction
zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory completes current request this cycle
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = write
i_or_d_o  output  1  address select: 0 PC, 1 ALUOut
ir_write_o  output  1  load IR and OldPC
pc_write_o  output  1  load PC
pc_src_o  output  1  0 ALU result, 1 ALUOut
alu_src_a_o  output  2  00 PC, 01 OldPC, 10 rs1 reg A
alu_src_b_o  output  2  00 rs2 reg B, 01 immediate, 10 constant 4
alu_op_o  output  3  000 R, 001 I, 010 add, 011 compare/subtract (new ALU-control entry), 100 LUI
reg_write_o  output  1  register-file write
result_src_o  output  2  00 ALUOut, 01 MDR, 10 PC
illegal_o  output  1  unsupported opcode, one-cycle pulse
state_o  output  4  current state code
instr_count_o  output  COUNT_W  retired instructions

Behaviour:
- Reset (async, reset=0): state FETCH, instr_count_o=0; outputs immediately take FETCH values. Reset mid-memory-access aborts it (mem_we_o drops at once).
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, EXEC_LUI 8, ALU_WB 9, BRANCH 10, JAL 11. Codes 12-15 are unreachable and recover to FETCH next cycle with all strobes 0.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, i_or_d=0, a=00, b=10, op=010.
  - mem_ready_i=1: ir_write=1, pc_write=1, pc_src=0; advance to DECODE.
  - mem_ready_i=0: hold state; ir_write=0, pc_write=0.
- DECODE: a=01, b=01, op=010 (ALUOut = branch/JAL target). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> EXEC_LUI
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other -> illegal_o=1 this cycle, next FETCH (acts as NOP; PC already advanced).
- EXEC_R: a=10, b=00, op=000 -> ALU_WB.
- EXEC_I: a=10, b=01, op=001 -> ALU_WB.
- EXEC_LUI: a=10, b=01, op=100 -> ALU_WB.
- ALU_WB: reg_write=1, result_src=00 -> FETCH.
- MEM_ADDR: a=10, b=01, op=010 -> MEM_RD for opcode 0000011, MEM_WR for 0100011.
- MEM_RD: mem_req=1, i_or_d=1, we=0. Hold until mem_ready_i=1 (datapath latches MDR), then MEM_WB.
- MEM_WB: reg_write=1, result_src=01 -> FETCH.
- MEM_WR: mem_req=1, i_or_d=1, we=1. Hold until mem_ready_i=1 -> FETCH.
- BRANCH: a=10, b=00, op=011; pc_src=1; pc_write=zero_i (same-cycle, combinational) -> FETCH.
- JAL: reg_write=1, result_src=10 (rd = PC = OldPC+4); pc_write=1, pc_src=1 -> FETCH.
- mem_req_o stays high and address/we stable while waiting; mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- instr_count_o increments by 1 on the clock edge leaving ALU_WB, MEM_WB, BRANCH, JAL, or MEM_WR with mem_ready_i=1. Illegal opcodes are not counted. Wraps modulo 2^COUNT_W.
- Latency with zero wait states:
  - R/I/LUI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ, JAL: 3 cycles
  - Each cycle mem_ready_i is low in a memory state adds one cycle.

Test Plan:
- reset low then high, mem_ready_i=1, opcode 0110011 -> states 0,1,6,9,0; reg_write_o high only in state 9; alu_op_o=000 in state 6; instr_count_o=1 after 4 clocks.
- LW (0000011), mem_ready_i low 3 cycles in MEM_RD -> states 0,1,2,3,3,3,3,4,0; mem_req_o/i_or_d_o held 1, no reg_write_o until state 4; count +1 after 8 clocks.
- BEQ (1100011) with zero_i=1 -> pc_write_o=1, pc_src_o=1 in state 10. Repeat with zero_i=0 -> pc_write_o=0. Count +1 both times.
- opcode 0000000 -> illegal_o=1 for exactly one cycle in DECODE, next state FETCH, count unchanged.
- mem_ready_i=0 for 5 cycles in FETCH -> ir_write_o and pc_write_o stay 0, state_o stays 0; the cycle ready rises, both strobes pulse once.
- SW (0100011), assert reset in MEM_WR before ready -> mem_we_o=0 and state_o=0 without a clock edge, count=0; after release, normal fetch resumes.
